// File: rtl/bs_link_pkg.sv
// ============================================================================
// bs_link_pkg : attack-link constants, receiver state type, baud helper
// Rev 1.0
// ============================================================================
`default_nettype none

package bs_link_pkg;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

`default_nettype wire

// File: rtl/baud_counter.sv
// ============================================================================
// baud_counter : loadable down-counter with a single-cycle expire tick
// Rev 1.0
// ============================================================================
`default_nettype none

module baud_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             expire_o
);

   logic [WIDTH-1:0] count_q;
   logic             armed_q;

   // armed_q drops after the tick so an idle counter parked at zero stays quiet
   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
         armed_q <= 1'b0;
      end else if (load_i) begin
         count_q <= load_val_i;
         armed_q <= 1'b1;
      end else if (expire_o) begin
         armed_q <= 1'b0;
      end else if (armed_q) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign expire_o = armed_q && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/attack_uart_rx.sv
// ============================================================================
// attack_uart_rx : attack-vector UART receiver; ATTACK_UART_PARITY_EN adds
// an even-parity bit after the data bits. Rev 1.0
// ============================================================================
`default_nettype none

module attack_uart_rx
   import bs_link_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
   localparam int CNT_W = $clog2(CPB);
   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
`ifdef ATTACK_UART_PARITY_EN
   localparam rx_state_t AFTER_DATA = PARITY;
`else
   localparam rx_state_t AFTER_DATA = STOP;
`endif

   logic                 rx_meta_q, rx_s_q;
   rx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_w;
   logic                 cnt_load;
   logic [CNT_W-1:0]     cnt_val;
   logic                 expire;
   logic                 par_bad;

   baud_counter #(.WIDTH(CNT_W)) u_baud (
      .clk        (clk),
      .clr        (clr),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .expire_o   (expire)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         rx_meta_q <= IDLE_LEVEL;
         rx_s_q    <= IDLE_LEVEL;
         state_q   <= IDLE;
         shift_q   <= '0;
         data_q    <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         state_q   <= state_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

`ifdef ATTACK_UART_PARITY_EN
   logic par_bad_q;
   always_ff @(posedge clk) begin
      if (clr)
         par_bad_q <= 1'b0;
      else if (state_q == PARITY && expire)
         par_bad_q <= rx_s_q ^ (^shift_q);
   end
   assign par_bad = par_bad_q;
`else
   assign par_bad = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (rx_s_q == START_LEVEL) state_d = START;
         START:  if (expire) state_d = (rx_s_q == START_LEVEL) ? DATA : IDLE;
         DATA:   if (expire && idx_q == LAST_IDX) state_d = AFTER_DATA;
         PARITY: if (expire) state_d = STOP;
         STOP:   if (expire) state_d = (rx_s_q == IDLE_LEVEL) ? IDLE : BREAK;
         BREAK:  if (rx_s_q == IDLE_LEVEL) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = FULL_LOAD;
      shift_d  = shift_q;
      data_d   = data_q;
      idx_d    = idx_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      busy_w   = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_s_q == START_LEVEL) begin
               cnt_load = 1'b1;
               cnt_val  = HALF_LOAD;
            end
         end
         START: begin
            if (expire && rx_s_q == START_LEVEL) begin
               cnt_load = 1'b1;
               idx_d    = '0;
            end
         end
         DATA: begin
            busy_w = 1'b1;
            if (expire) begin
               shift_d  = {rx_s_q, shift_q[DATA_BITS-1:1]};
               idx_d    = idx_q + IDX_W'(1);
               cnt_load = 1'b1;
            end
         end
         PARITY: begin
            busy_w = 1'b1;
            if (expire) cnt_load = 1'b1;
         end
         STOP: begin
            busy_w = 1'b1;
            if (expire) begin
               if (rx_s_q == IDLE_LEVEL && !par_bad) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         BREAK:   busy_w = 1'b1;
         default: busy_w = 1'b0;
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = busy_w;

endmodule

`default_nettype wire

// File: tb/tb_attack_uart_rx.sv
// ============================================================================
// tb_attack_uart_rx : directed and random frames against a frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_attack_uart_rx;

   localparam int CPB = 16;
`ifdef ATTACK_UART_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int LAT = 2 + CPB / 2 + (8 + 1 + PAR_BITS) * CPB;

   typedef struct {
      bit         err;
      logic [7:0] d;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, busy;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_err = 0;
   int         t0 = 0;
   ev_t        evq[$];
   bit         busy_seen = 1'b0;
   logic [7:0] data_s = 8'h00;
   logic       busy_s = 1'b0;
   logic [7:0] model_data;
   logic [7:0] rd;
   logic       rstp, rpar;
   bit         rbad;

   attack_uart_rx #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8)) dut (
      .clk       (clk),
      .clr       (clr),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      data_s = data;
      busy_s = busy;
      if (busy) busy_seen = 1'b1;
      if (valid || frame_err) begin
         check_eq("valid_and_err_exclusive", 32'(valid & frame_err), 32'd0);
         evq.push_back('{err: frame_err, d: data, cyc: cyc});
      end
   end

   task automatic put_bit(input logic b, input bit pulse_clr);
      #1 rx = b;
      if (pulse_clr) begin
         repeat (CPB / 2) @(posedge clk);
         #1 clr = 1'b1;
         @(posedge clk);
         #1 clr = 1'b0;
         repeat (CPB / 2 - 1) @(posedge clk);
      end else begin
         repeat (CPB) @(posedge clk);
      end
   endtask

   // Called on a rising edge; returns on the edge that ends the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic stp, input logic par, input int abort_bit);
      #1 rx = 1'b0;
      t0 = cyc + 1;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) put_bit(d[i], i == abort_bit);
      if (PAR_BITS == 1) put_bit(par, 1'b0);
      put_bit(stp, 1'b0);
   endtask

   task automatic check_frame(input bit exp_err, input logic [7:0] exp_d);
      ev_t ev;
      int  lat;
      check_eq("event_count", evq.size(), 1);
      if (evq.size() > 0) begin
         ev = evq.pop_front();
         check_eq("event_is_err", 32'(ev.err), 32'(exp_err));
         if (!exp_err) check_eq("valid_data", 32'(ev.d), 32'(exp_d));
         lat = ev.cyc - t0;
         check_eq("latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
      end
      evq.delete();
      check_eq("data_out", 32'(data_s), 32'(model_data));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_data", 32'(data), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_frame_err", 32'(frame_err), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      clr = 1'b0;
      @(posedge clk);

      send_frame(8'hA5, 1'b1, ^8'hA5, -1);
      model_data = 8'hA5;
      check_frame(1'b0, 8'hA5);
      repeat (20) @(posedge clk);
      check_eq("a5_no_extra_event", evq.size(), 0);

      busy_seen = 1'b0;
      #1 rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx = 1'b1;
      repeat (40) @(posedge clk);
      check_eq("glitch_busy", 32'(busy_seen), 32'd0);
      check_eq("glitch_events", evq.size(), 0);
      check_eq("glitch_data", 32'(data_s), 32'(model_data));

      send_frame(8'h3C, 1'b0, ^8'h3C, -1);
      repeat (40) @(posedge clk);
      check_frame(1'b1, 8'h3C);
      check_eq("break_busy_held", 32'(busy_s), 32'd1);
      #1 rx = 1'b1;
      repeat (4) @(posedge clk);
      check_eq("break_released", 32'(busy_s), 32'd0);

      send_frame(8'h01, 1'b1, ^8'h01, -1);
      model_data = 8'h01;
      check_frame(1'b0, 8'h01);
      send_frame(8'h80, 1'b1, ^8'h80, -1);
      model_data = 8'h80;
      check_frame(1'b0, 8'h80);

      send_frame(8'hFF, 1'b1, ^8'hFF, 3);
      model_data = 8'h00;
      repeat (4) @(posedge clk);
      check_eq("abort_events", evq.size(), 0);
      check_eq("abort_data", 32'(data_s), 32'd0);
      send_frame(8'h42, 1'b1, ^8'h42, -1);
      model_data = 8'h42;
      check_frame(1'b0, 8'h42);

`ifdef ATTACK_UART_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0, -1);
      check_frame(1'b1, 8'h07);
      send_frame(8'h07, 1'b1, 1'b1, -1);
      model_data = 8'h07;
      check_frame(1'b0, 8'h07);
`endif

      for (int k = 0; k < 12; k++) begin
         rd   = 8'($urandom);
         rstp = ($urandom_range(0, 3) != 0);
         rpar = ^rd;
         if (PAR_BITS == 1 && $urandom_range(0, 3) == 0) rpar = ~rpar;
         rbad = !rstp || (PAR_BITS == 1 && rpar != ^rd);
         send_frame(rd, rstp, rpar, -1);
         if (!rbad) model_data = rd;
         check_frame(rbad, rd);
         if (!rstp) begin
            #1 rx = 1'b1;
            repeat (3) @(posedge clk);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/attack_uart_rx.md
Name: attack_uart_rx

Overview:
- Slave-board receiver for the attack link; the master board serialises its registered 8-bit attack vector over one UART-style wire.
- Deserialises each frame back into an 8-bit attack vector and presents it with a one-cycle valid strobe.
- Output feeds the slave's hit logic, which ANDs it with the ship register.
- Also flags malformed frames so the slave FSM can ignore them.

Parameters:
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BAUD, 9600: link bit rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated; must be >= 4.
- DATA_BITS, 8: payload bits per frame; matches the board attack width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  synchronous active-high reset; shares the game-wide clear.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data  out  DATA_BITS  last good attack vector, LSB = position 0.
- valid  out  1  one-cycle pulse; data updated this cycle.
- frame_err  out  1  one-cycle pulse on a bad stop bit (or bad parity, see option).
- busy  out  1  high from confirmed start bit until return to IDLE.

Behaviour:
- Reset values:
  - data = 0, valid = 0, frame_err = 0, busy = 0, state = IDLE.
  - Both rx synchroniser flops preset to 1, so no false start comes out of reset.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, [parity], 1 stop bit (1).
- States and transitions:
  - IDLE: rx_s == 0 -> START, bit counter loaded with CLKS_PER_BIT/2 - 1.
  - START: at counter expiry (mid start bit):
    - rx_s still 0 -> DATA; busy = 1; bit index = 0; counter reloaded to CLKS_PER_BIT - 1.
    - rx_s == 1 -> IDLE (glitch, false start); no outputs pulse.
  - DATA: at each expiry, shift rx_s into the MSB of the shift register. After DATA_BITS samples -> STOP (or PARITY when enabled).
  - STOP: at expiry:
    - rx_s == 1 -> data <= shift register, valid = 1 for exactly one cycle, -> IDLE.
    - rx_s == 0 -> frame_err = 1 for one cycle, data unchanged, -> BREAK.
  - BREAK: wait for rx_s == 1, then -> IDLE. A held-low line never retriggers.
- busy is 0 in IDLE and START; 1 in DATA, PARITY, STOP and BREAK.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after the first clk edge with rx low, +/-1 cycle.
- Back-to-back frames: a new start bit is accepted in the first IDLE cycle after the stop sample, so half a stop bit of margin is tolerated.
- clr overrides everything in the same edge. Mid-frame clr aborts with no valid and no frame_err; the partial byte is discarded.
- valid and frame_err are never high together.
- Counter and index widths: $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1). No wrap beyond the reload values.

Optional Feature:
- Macro: ATTACK_UART_PARITY_EN.
- Defined:
  - Adds a PARITY state after DATA, sampling one even-parity bit.
  - At STOP, a parity mismatch or a bad stop bit gives frame_err; data is not updated.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state; frame as above.
- The master-side transmitter must be built with the same setting.

Decomposition:
- Package bs_link_pkg holds:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK};
  - constant function clks_per_bit(CLK_HZ, BAUD);
  - the shared link constants IDLE_LEVEL = 1 and START_LEVEL = 0, also used by the transmitter.
- Sub-module baud_counter:
  - loadable down-counter with a load value input;
  - outputs a one-cycle expire tick;
  - reused by the transmitter.

Test Plan (sim with CLK_HZ=16, BAUD=1, so CLKS_PER_BIT=16):
- Send 0xA5 with a good stop -> data=0xA5; valid high exactly 1 cycle, 2+8+9*16=154 (+/-1) cycles after the start edge; frame_err stays 0.
- 4-cycle low glitch on idle rx -> busy never 1, no valid, no frame_err, data holds previous value.
- Send 0x3C with the stop bit low, then hold rx low 40 cycles -> one frame_err pulse, no valid, data unchanged, no retrigger until rx goes high.
- Send 0x01 immediately followed by 0x80 (one stop bit each) -> two valid pulses, data 0x01 then 0x80.
- Assert clr for 1 cycle during data bit 3 of 0xFF, then send 0x42 -> no output from the aborted frame; next valid carries 0x42.
- With ATTACK_UART_PARITY_EN: send 0x07 with parity bit 0 (wrong; correct is 1) -> frame_err pulse, data unchanged. Resend with parity 1 -> valid, data=0x07.
